boreal_pwm_capture: RTL and testbench

//  PWM capture/decoder: the receive end of the 12-bit articulation PWM link. Samples an async
//  PWM input on the 100MHz clk, measures high time and period in clk cycles, and publishes
//  a 12-bit duty word plus raw counts once per period. Also flags stuck-high/low lines.

---
 rtl/boreal_pwm_capture_if.sv | 15 +
 rtl/boreal_pwm_capture.sv | 139 +++++++++++++
 tb/tb_boreal_pwm_capture.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/boreal_pwm_capture_if.sv
// boreal_pwm_capture_if: PWM input and measurement outputs of boreal_pwm_capture.
`timescale 1ns/1ps
interface boreal_pwm_capture_if #(
   parameter int CNT_W = 16
);
   logic             pwm_in;
   logic [11:0]      duty_out;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             meas_valid;
   logic             stuck_hi;
   logic             stuck_lo;
   modport master (input pwm_in, output duty_out, high_cnt, period_cnt, meas_valid, stuck_hi, stuck_lo);
   modport slave (output pwm_in, input duty_out, high_cnt, period_cnt, meas_valid, stuck_hi, stuck_lo);
endinterface

// File: rtl/boreal_pwm_capture.sv
// boreal_pwm_capture: PWM high-time/period decoder with stuck-line detection.
// Define PWM_CAP_GLITCH_FILTER_EN to add a FILT_LEN-cycle stability filter on the synced input.
`timescale 1ns/1ps
module boreal_pwm_capture #(
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 8192,
   parameter int FILT_LEN    = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   boreal_pwm_capture_if.master bus
);
   typedef enum logic [1:0] {SYNC, HIGH, LOW, STUCK} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   if (FILT_LEN < 1 || TIMEOUT_CYC <= 4096 || TIMEOUT_CYC >= 2**CNT_W || CNT_W < 12) begin : g_bad_param
      $error("boreal_pwm_capture: illegal parameter set");
   end
   state_t           state, state_nx;
   logic             s1, s2, lvl, lvl_d, rise, fall, armed, timeout;
   logic             publish, to_hi, to_lo, clr;
   logic [1:0]       pr;
   logic [CNT_W-1:0] cnt, hi_tmp;
   logic [CNT_W:0]   sum;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         lvl_d <= 1'b0;
         pr    <= '0;
         armed <= 1'b0;
      end else begin
         s1    <= bus.pwm_in;
         s2    <= s1;
         lvl_d <= lvl;
         pr    <= {pr[0], 1'b1};
         armed <= armed | (pr[1] & ~s2 & ~lvl);
      end
`ifdef PWM_CAP_GLITCH_FILTER_EN
   localparam int SW = $clog2(FILT_LEN + 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(FILT_LEN - 1);
   logic [SW-1:0] stab;
   logic          filt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         filt <= 1'b0;
         stab <= '0;
      end else if (s2 == filt) begin
         stab <= '0;
      end else if (stab == STAB_LAST) begin
         filt <= s2;
         stab <= '0;
      end else begin
         stab <= stab + SW'(1);
      end
   assign lvl = filt;
`else
   assign lvl = s2;
`endif
   assign rise    = lvl & ~lvl_d;
   assign fall    = ~lvl & lvl_d;
   assign timeout = (cnt == TO_LAST) & ~rise & ~fall;
   assign sum     = {1'b0, hi_tmp} + {1'b0, cnt};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= SYNC;
      else state <= state_nx;
   // A rise in SYNC counts only once the line has been seen low with real synchronizer data,
   // so a line already high at reset release never yields a partial first period.
   always_comb begin
      state_nx = state;
      publish  = 1'b0;
      to_hi    = 1'b0;
      to_lo    = 1'b0;
      clr      = 1'b0;
      case (state)
         SYNC: begin
            if (rise && armed) state_nx = HIGH;
            else if (timeout) begin
               state_nx = STUCK;
               to_hi    = lvl;
               to_lo    = ~lvl;
            end
         end
         HIGH: begin
            if (fall) state_nx = LOW;
            else if (timeout) begin
               state_nx = STUCK;
               to_hi    = 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               state_nx = HIGH;
               publish  = 1'b1;
            end else if (timeout) begin
               state_nx = STUCK;
               to_lo    = 1'b1;
            end
         end
         default: begin
            state_nx = rise ? HIGH : fall ? SYNC : STUCK;
            clr      = rise | fall;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt            <= '0;
         hi_tmp         <= '0;
         bus.duty_out   <= '0;
         bus.high_cnt   <= '0;
         bus.period_cnt <= '0;
         bus.meas_valid <= 1'b0;
         bus.stuck_hi   <= 1'b0;
         bus.stuck_lo   <= 1'b0;
      end else begin
         bus.meas_valid <= publish | to_hi | to_lo;
         if (rise || fall) cnt <= CNT_W'(1);
         else if (state != STUCK) cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
         if (fall) hi_tmp <= cnt;
         if (publish) begin
            bus.high_cnt   <= hi_tmp;
            bus.period_cnt <= sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
            bus.duty_out   <= (hi_tmp > CNT_W'(12'hFFF)) ? 12'hFFF : hi_tmp[11:0];
         end
         if (to_hi) begin
            bus.stuck_hi <= 1'b1;
            bus.duty_out <= 12'hFFF;
         end
         if (to_lo) begin
            bus.stuck_lo <= 1'b1;
            bus.duty_out <= 12'h000;
         end
         if (clr) begin
            bus.stuck_hi <= 1'b0;
            bus.stuck_lo <= 1'b0;
         end
      end
endmodule

// File: tb/tb_boreal_pwm_capture.sv
// tb_boreal_pwm_capture: scoreboard bench for boreal_pwm_capture; expectations queued by
// stimulus, popped by a monitor on every meas_valid.
`timescale 1ns/1ps
module tb_boreal_pwm_capture;
   typedef struct {
      int hi;
      int per;
      int duty;
      bit shi;
      bit slo;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];
   boreal_pwm_capture_if #(.CNT_W(16)) bus ();
   boreal_pwm_capture #(.CNT_W(16), .TIMEOUT_CYC(8192), .FILT_LEN(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_duty"}, bus.duty_out, 0);
      chk({tag, "_high"}, bus.high_cnt, 0);
      chk({tag, "_period"}, bus.period_cnt, 0);
      chk({tag, "_valid"}, bus.meas_valid, 0);
      chk({tag, "_stuck_hi"}, bus.stuck_hi, 0);
      chk({tag, "_stuck_lo"}, bus.stuck_lo, 0);
   endtask
   task automatic push(input int hi, input int per, input int duty, input bit shi, input bit slo);
      exp_t e;
      e.hi = hi;
      e.per = per;
      e.duty = duty;
      e.shi = shi;
      e.slo = slo;
      sb.push_back(e);
   endtask
   task automatic pwm(input int h, input int p);
      push(h, p, (h > 4095) ? 4095 : h, 1'b0, 1'b0);
      @(negedge clk) bus.pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (p - h - 1) @(negedge clk);
   endtask
   task automatic pwm_glitch(input int h, input int p, input int goff, input int glen);
`ifdef PWM_CAP_GLITCH_FILTER_EN
      push(h, p, h, 1'b0, 1'b0);
`else
      push(h, goff, h, 1'b0, 1'b0);
      push(glen, p - goff, glen, 1'b0, 1'b0);
`endif
      @(negedge clk) bus.pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (goff - h) @(negedge clk);
      bus.pwm_in = 1'b1;
      repeat (glen) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (p - goff - glen - 1) @(negedge clk);
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.meas_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_publish: got high=%0d period=%0d duty=%0d shi=%0b slo=%0b, none expected",
                        bus.high_cnt, bus.period_cnt, bus.duty_out, bus.stuck_hi, bus.stuck_lo);
            end else begin
               e = sb.pop_front();
               if (bus.high_cnt != 16'(e.hi) || bus.period_cnt != 16'(e.per) || bus.duty_out != 12'(e.duty) ||
                   bus.stuck_hi != e.shi || bus.stuck_lo != e.slo) begin
                  n_err++;
                  $display("FAIL publish: got high=%0d period=%0d duty=%0d shi=%0b slo=%0b expected high=%0d period=%0d duty=%0d shi=%0b slo=%0b",
                           bus.high_cnt, bus.period_cnt, bus.duty_out, bus.stuck_hi, bus.stuck_lo,
                           e.hi, e.per, e.duty, e.shi, e.slo);
               end
            end
         end
      end
   end
   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end
   initial begin : stim
      bus.pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      // duty 1000 then duty 4095
      repeat (3) pwm(1000, 4096);
      repeat (2) pwm(4095, 4096);
      // line held low after one more high phase -> stuck_lo
      push(4095, 4096, 0, 1'b0, 1'b1);
      @(negedge clk) bus.pwm_in = 1'b1;
      repeat (1000) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (8000) @(negedge clk);
      chk("stuck_lo_early", bus.stuck_lo, 0);
      repeat (1000) @(negedge clk);
      chk("stuck_lo_set", bus.stuck_lo, 1);
      chk("stuck_lo_duty", bus.duty_out, 0);
      chk("stuck_lo_hi_clear", bus.stuck_hi, 0);
      pwm(1000, 4096);
      chk("stuck_lo_cleared", bus.stuck_lo, 0);
      // line held high -> stuck_hi
      push(1000, 4096, 4095, 1'b1, 1'b0);
      @(negedge clk) bus.pwm_in = 1'b1;
      repeat (8000) @(negedge clk);
      chk("stuck_hi_early", bus.stuck_hi, 0);
      repeat (2000) @(negedge clk);
      chk("stuck_hi_set", bus.stuck_hi, 1);
      chk("stuck_hi_duty", bus.duty_out, 4095);
      chk("stuck_hi_lo_clear", bus.stuck_lo, 0);
      bus.pwm_in = 1'b0;
      repeat (50) @(negedge clk);
      chk("stuck_hi_cleared", bus.stuck_hi, 0);
      chk("stuck_hi_duty_hold", bus.duty_out, 4095);
      // reset in the middle of a high phase
      pwm(1000, 4096);
      @(negedge clk) bus.pwm_in = 1'b1;
      repeat (500) @(negedge clk);
      chk("pre_reset_duty", bus.duty_out, 1000);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk_zero("mid_reset");
      rst_n = 1'b1;
      repeat (500) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (3000) @(negedge clk);
      chk("post_reset_no_publish", bus.period_cnt, 0);
      repeat (2) pwm(1000, 4096);
      // 2-cycle glitch inside the low phase
      pwm_glitch(1000, 4096, 2000, 2);
      pwm(1000, 4096);
      @(negedge clk) bus.pwm_in = 1'b1;
      repeat (20) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (20) @(negedge clk);
      chk("pending_expected", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
